// File: rtl/regfile_sb_if.sv
// Register file port bundle: decode read/alloc, writeback write, debug read.
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              hazard;
  logic              ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd1_addr, rd2_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, dbg_addr,
    input  rd1_data, rd2_data, hazard, ready, dbg_data
  );
  modport slave (
    input  rd1_addr, rd2_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, dbg_addr,
    output rd1_data, rd2_data, hazard, ready, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R/1W register file with sequenced clear, pending-write scoreboard and debug port.
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  logic [0:0]                   state;
  logic [ADDR_W:0]              init_cnt;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pending;
  logic                         ready, wr_ok, alloc_ok, byp1, byp2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign ready    = (state == S_RUN);
  assign wr_ok    = ready & bus.wr_en & ~is_zero(bus.wr_addr);
  assign alloc_ok = ready & bus.alloc_en & ~is_zero(bus.alloc_addr);

`ifdef REGFILE_BYPASS_EN
  // wr_ok already excludes the hard-wired zero register and the INIT phase
  assign byp1 = wr_ok & (bus.wr_addr == bus.rd1_addr);
  assign byp2 = wr_ok & (bus.wr_addr == bus.rd2_addr);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + (ADDR_W+1)'(1);
      if (init_cnt == LAST) state <= S_RUN;
    end
  end

  // Storage carries no reset: the INIT sweep zeroes every entry before use
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT) regs[init_cnt[ADDR_W-1:0]] <= '0;
      else if (wr_ok)      regs[bus.wr_addr]          <= bus.wr_data;
    end
  end

  // Alloc is evaluated last so a same-cycle newer producer keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (wr_ok)    pending[bus.wr_addr]    <= 1'b0;
      if (alloc_ok) pending[bus.alloc_addr] <= 1'b1;
    end
  end

  always_comb begin
    bus.rd1_data = '0;
    bus.rd2_data = '0;
    bus.dbg_data = '0;
    if (ready) begin
      if (!is_zero(bus.rd1_addr)) bus.rd1_data = byp1 ? bus.wr_data : regs[bus.rd1_addr];
      if (!is_zero(bus.rd2_addr)) bus.rd2_data = byp2 ? bus.wr_data : regs[bus.rd2_addr];
      bus.dbg_data = regs[bus.dbg_addr];
    end
  end

  assign bus.hazard = ready & ((pending[bus.rd1_addr] & ~byp1) |
                               (pending[bus.rd2_addr] & ~byp2));
  assign bus.ready  = ready;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed + randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  localparam bit ZR = 1'b1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR ? 1 : 0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model
  int mregs [DEPTH];
  bit mpend [DEPTH];
  bit m_run = 1'b0;
  bit m_known = 1'b0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit zaddr(input int a);
    return ZR && (a == 0);
  endfunction

  function automatic bit fwd(input bit we, input int wa, input int a);
    return BYP && m_run && we && (wa == a) && !zaddr(a);
  endfunction

  function automatic int exp_rd(input int a, input bit we, input int wa, input int wd);
    if (!m_run || zaddr(a)) return 0;
    if (fwd(we, wa, a)) return wd;
    return mregs[a];
  endfunction

  task automatic cyc(input bit rst, input bit we, input int wa, input int wd,
                     input bit ae, input int aa, input int a1, input int a2, input int da);
    bit h;
    reset = rst;
    bus.wr_en = we;  bus.wr_addr = AW'(wa);  bus.wr_data = DW'(wd);
    bus.alloc_en = ae;  bus.alloc_addr = AW'(aa);
    bus.rd1_addr = AW'(a1);  bus.rd2_addr = AW'(a2);  bus.dbg_addr = AW'(da);
    #3;
    if (m_known) begin
      h = m_run && ((mpend[a1] && !fwd(we, wa, a1)) || (mpend[a2] && !fwd(we, wa, a2)));
      chk("ready",  32'(bus.ready),    32'(m_run));
      chk("rd1",    32'(bus.rd1_data), 32'(exp_rd(a1, we, wa, wd)));
      chk("rd2",    32'(bus.rd2_data), 32'(exp_rd(a2, we, wa, wd)));
      chk("hazard", 32'(bus.hazard),   32'(h));
      chk("dbg",    32'(bus.dbg_data), m_run ? 32'(mregs[da]) : 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0;  m_cnt = 0;  m_known = 1'b1;
      foreach (mpend[i]) mpend[i] = 1'b0;
    end else if (!m_run) begin
      mregs[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      if (we && !zaddr(wa)) begin mregs[wa] = wd; mpend[wa] = 1'b0; end
      if (ae && !zaddr(aa)) mpend[aa] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n, input int a1, input int a2);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, a1, a2, i % DEPTH);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mregs[i]) mregs[i] = 0;
    // reset, then DEPTH cycles of INIT before ready
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(DEPTH + 1, 1, 2);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, i);
    chk("ready_after_init", 32'(bus.ready), 32'd1);
    // write then read back
    cyc(0, 1, 3, 'hE0, 0, 0, 3, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 0, 3);
    // RAW hazard, resolved by writeback
    cyc(0, 0, 0, 0, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 4, 4);
    cyc(0, 1, 4, 'hEF, 0, 0, 0, 4, 4);
    cyc(0, 0, 0, 0, 0, 0, 0, 4, 4);
    // same-cycle alloc and write: data lands, pending stays set
    cyc(0, 1, 2, 'h5A, 1, 2, 2, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 2, 0, 2);
    // hard-wired zero register
    cyc(0, 1, 0, 'h55, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-INIT restarts the sweep and clears pending
    cyc(1, 0, 0, 0, 0, 0, 2, 2, 0);
    idle(5, 2, 2);
    cyc(1, 0, 0, 0, 0, 0, 2, 2, 0);
    idle(DEPTH + 2, 2, 2);
    chk("pend_cleared", 32'(bus.hazard), 32'd0);
    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 255)),
          $urandom_range(0, 4) < 2, int'($urandom_range(0, DEPTH-1)),
          int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)),
          int'($urandom_range(0, DEPTH-1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
